// File: rtl/disp_wta_sequencer.sv
// disp_wta_sequencer
// Time-multiplexed winner-take-all disparity search. Each pixel's cost vector
// arrives as NCHUNK beats of CHUNK costs. One CHUNK-wide arg-min stage is
// reused across the beats. A running minimum is kept, and one disparity is
// emitted per pixel through a single registered AXI-Stream output slot.
module disp_wta_sequencer #(
    parameter int MAX_DISP   = 64,
    parameter int CHUNK      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CHUNK*DATA_WIDTH-1:0] s_axis_costs_tdata,
    input  logic                        s_axis_costs_tvalid,
    output logic                        s_axis_costs_tready,
    input  logic                        s_axis_costs_tuser,
    input  logic                        s_axis_costs_tlast,
    output logic [DATA_WIDTH-1:0]       m_axis_min_tdata,
    output logic                        m_axis_min_tvalid,
    input  logic                        m_axis_min_tready,
    output logic                        m_axis_min_tuser,
    output logic                        m_axis_min_tlast,
    output logic                        sync_err,
    output logic                        busy
);

    localparam int NCHUNK = MAX_DISP / CHUNK;
    localparam int LANE_W = $clog2(CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    // CHUNK is a power of two, so {chunk_idx, lane} == chunk_idx*CHUNK + lane.
    localparam int DISP_W = IDX_W + LANE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    // State registers
    logic [IDX_W-1:0]      chunk_idx_q, chunk_idx_d;
    logic [DATA_WIDTH-1:0] run_min_q,   run_min_d;
    logic [DISP_W-1:0]     run_arg_q,   run_arg_d;
    logic                  run_user_q,  run_user_d;
    logic [DATA_WIDTH-1:0] m_tdata_q,   m_tdata_d;
    logic                  m_tvalid_q,  m_tvalid_d;
    logic                  m_tuser_q,   m_tuser_d;
    logic                  m_tlast_q,   m_tlast_d;
    logic                  sync_err_q,  sync_err_d;

    // Combinational intermediates
    logic [DATA_WIDTH-1:0] lane_min;
    logic [LANE_W-1:0]     lane_arg;
    logic                  in_ready;
    logic                  accept;
    logic                  restart;
    logic [IDX_W-1:0]      eff_idx;
    logic                  first_c;
    logic                  final_c;
    logic                  load_out;
    logic [DISP_W-1:0]     cand_arg;

    // Lane arg-min over the current beat. The strict compare keeps ties on the lowest lane.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
        lane_min = s_axis_costs_tdata[DATA_WIDTH-1:0];
        lane_arg = '0;
        for (int k = 1; k < CHUNK; k++) begin
            if (s_axis_costs_tdata[k*DATA_WIDTH +: DATA_WIDTH] < lane_min) begin
                lane_min = s_axis_costs_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                lane_arg = LANE_W'(k);
            end
        end
    end

    // Handshake, framing, accumulation and output next-state logic
    always_comb begin
        // The final chunk may only be taken when the output slot can free up this cycle.
        in_ready = !((chunk_idx_q == LAST_IDX) && m_tvalid_q && !m_axis_min_tready);
        accept   = s_axis_costs_tvalid && in_ready;

        // A start-of-frame mid-pixel drops the partial pixel and restarts at chunk 0.
        restart  = s_axis_costs_tuser && (chunk_idx_q != '0);
        eff_idx  = restart ? '0 : chunk_idx_q;
        first_c  = (eff_idx == '0);
        final_c  = (eff_idx == LAST_IDX);
        cand_arg = {eff_idx, lane_arg};
        load_out = accept && final_c;

        chunk_idx_d = chunk_idx_q;
        run_min_d   = run_min_q;
        run_arg_d   = run_arg_q;
        run_user_d  = run_user_q;
        sync_err_d  = 1'b0;

        if (accept) begin
            chunk_idx_d = final_c ? '0 : eff_idx + IDX_W'(1);
            // Only a strictly smaller chunk minimum wins, so ties keep the lower disparity.
            if (first_c || (lane_min < run_min_q)) begin
                run_min_d = lane_min;
                run_arg_d = cand_arg;
            end
            if (first_c) begin
                run_user_d = s_axis_costs_tuser;
            end
            // Both violations in one beat still raise a single pulse.
            sync_err_d = restart || (s_axis_costs_tlast && !final_c);
        end

        m_tdata_d  = m_tdata_q;
        m_tuser_d  = m_tuser_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;
        if (load_out) begin
            m_tdata_d  = DATA_WIDTH'(run_arg_d);
            m_tuser_d  = first_c ? s_axis_costs_tuser : run_user_q;
            m_tlast_d  = s_axis_costs_tlast;
            m_tvalid_d = 1'b1;
        end else if (m_axis_min_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    // State update with asynchronous clear
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            chunk_idx_q <= '0;
            run_min_q   <= '0;
            run_arg_q   <= '0;
            run_user_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tuser_q   <= 1'b0;
            m_tlast_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            chunk_idx_q <= chunk_idx_d;
            run_min_q   <= run_min_d;
            run_arg_q   <= run_arg_d;
            run_user_q  <= run_user_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tuser_q   <= m_tuser_d;
            m_tlast_q   <= m_tlast_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign s_axis_costs_tready = in_ready;
    assign m_axis_min_tdata    = m_tdata_q;
    assign m_axis_min_tvalid   = m_tvalid_q;
    assign m_axis_min_tuser    = m_tuser_q;
    assign m_axis_min_tlast    = m_tlast_q;
    assign sync_err            = sync_err_q;
    assign busy                = (chunk_idx_q != '0);

endmodule

// File: tb/tb_disp_wta_sequencer.sv
// Self-checking bench for disp_wta_sequencer. The reference model is a plain
// first-minimum search over the whole 64-entry cost vector. Outputs are
// collected by a negedge monitor and compared per scenario.
module tb_disp_wta_sequencer;

    localparam int MAX_DISP = 64;
    localparam int CHUNK    = 8;
    localparam int DW       = 8;
    localparam int NCHUNK   = MAX_DISP / CHUNK;

    logic              aclk;
    logic              aresetn;
    logic [CHUNK*DW-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tuser;
    logic              s_tlast;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tuser;
    logic              m_tlast;
    logic              sync_err;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_bp = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
        int            cyc;
    } rec_t;

    rec_t obs_q[$];
    rec_t exp_q[$];
    logic [DW-1:0] pix [MAX_DISP];

    disp_wta_sequencer #(.MAX_DISP(MAX_DISP), .CHUNK(CHUNK), .DATA_WIDTH(DW)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .s_axis_costs_tdata (s_tdata),
        .s_axis_costs_tvalid(s_tvalid),
        .s_axis_costs_tready(s_tready),
        .s_axis_costs_tuser (s_tuser),
        .s_axis_costs_tlast (s_tlast),
        .m_axis_min_tdata   (m_tdata),
        .m_axis_min_tvalid  (m_tvalid),
        .m_axis_min_tready  (m_tready),
        .m_axis_min_tuser   (m_tuser),
        .m_axis_min_tlast   (m_tlast),
        .sync_err           (sync_err),
        .busy               (busy)
    );

    initial aclk = 0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Record every output transfer; inputs only change 1 time unit after a rising edge.
    always @(negedge aclk) begin
        if (aresetn && m_tvalid && m_tready)
            obs_q.push_back('{d: m_tdata, u: m_tuser, l: m_tlast, cyc: cyc});
    end

    // Reference: index of the first minimum over the whole vector.
    function automatic int ref_argmin();
        int best = 0;
        for (int d = 1; d < MAX_DISP; d++)
            if (pix[d] < pix[best]) best = d;
        return best;
    endfunction

    function automatic void fill(input int v);
        for (int d = 0; d < MAX_DISP; d++) pix[d] = DW'(v);
    endfunction

    function automatic void fill_rand(input int hi);
        for (int d = 0; d < MAX_DISP; d++) pix[d] = DW'($urandom_range(0, hi));
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Present chunk c of pix and wait (bounded) for its handshake.
    task automatic send_beat(input int c, input logic u, input logic l);
        int n = 0;
        for (int k = 0; k < CHUNK; k++) s_tdata[k*DW +: DW] = pix[c*CHUNK + k];
        s_tvalid = 1'b1;
        s_tuser  = u;
        s_tlast  = l;
        while (!s_tready && n < 200) begin
            if (rand_bp) m_tready = 1'($urandom_range(0, 1));
            #0;
            if (s_tready) break;
            tick();
            n++;
        end
        if (!s_tready) begin
            checks++; errors++;
            $display("FAIL beat_timeout: chunk %0d s_tready stuck at %0b, required 1", c, s_tready);
        end
        tick();
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_pixel(input logic u, input logic l);
        for (int c = 0; c < NCHUNK; c++)
            send_beat(c, (c == 0) ? u : 1'b0, (c == NCHUNK-1) ? l : 1'b0);
    endtask

    task automatic test_reset();
        aresetn  = 0;
        s_tdata  = '0;
        s_tvalid = 0;
        s_tuser  = 0;
        s_tlast  = 0;
        m_tready = 1;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1;
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b, required 0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %0d, required 0", m_tdata); end
        checks++; if ({m_tuser, m_tlast, sync_err, busy} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b, required 0000", {m_tuser, m_tlast, sync_err, busy}); end
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready: got %0b, required 1", s_tready); end
        tick();
    endtask

    task automatic test_single_min();
        fill(200);
        pix[37] = 3;
        for (int c = 0; c < NCHUNK-1; c++) send_beat(c, 1'b0, 1'b0);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL early_valid: got %0b before final chunk, required 0", m_tvalid); end
        send_beat(NCHUNK-1, 1'b0, 1'b0);
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %0b one cycle after final beat, required 1", m_tvalid); end
        checks++; if (m_tdata !== DW'(37)) begin errors++; $display("FAIL single_min: got %0d, required 37", m_tdata); end
        tick();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL valid_clear: got %0b after drain, required 0", m_tvalid); end
        obs_q.delete();
    endtask

    task automatic test_ties();
        fill(9);
        pix[10] = 5;
        pix[50] = 5;
        send_pixel(1'b0, 1'b0);
        checks++; if (m_tdata !== DW'(10)) begin errors++; $display("FAIL tie_cross_chunk: got %0d, required 10", m_tdata); end
        fill(9);
        pix[16] = 0;
        pix[19] = 0;
        send_pixel(1'b0, 1'b0);
        checks++; if (m_tdata !== DW'(16)) begin errors++; $display("FAIL tie_in_chunk: got %0d, required 16", m_tdata); end
        tick();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        obs_q.delete();
        exp_q.delete();
        for (int p = 0; p < 3; p++) begin
            fill_rand(255);
            exp_q.push_back('{d: DW'(ref_argmin()), u: (p == 0), l: (p == 2), cyc: 0});
            send_pixel(p == 0, p == 2);
        end
        repeat (3) tick();
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d outputs, required 3", obs_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++; if ({obs_q[i].d, obs_q[i].u, obs_q[i].l} !== {exp_q[i].d, exp_q[i].u, exp_q[i].l}) begin
                errors++; $display("FAIL b2b_out%0d: got d=%0d u=%0b l=%0b, required d=%0d u=%0b l=%0b", i,
                    obs_q[i].d, obs_q[i].u, obs_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
            end
            if (i > 0) begin
                checks++; if (obs_q[i].cyc - obs_q[i-1].cyc != NCHUNK) begin
                    errors++; $display("FAIL b2b_spacing%0d: got %0d cycles, required %0d", i, obs_q[i].cyc - obs_q[i-1].cyc, NCHUNK);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_a, exp_b;
        obs_q.delete();
        m_tready = 0;
        fill_rand(255);
        exp_a = DW'(ref_argmin());
        send_pixel(1'b0, 1'b0);
        fill_rand(255);
        exp_b = DW'(ref_argmin());
        for (int c = 0; c < NCHUNK-1; c++) send_beat(c, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %0b, required 1", busy); end
        for (int k = 0; k < CHUNK; k++) s_tdata[k*DW +: DW] = pix[(NCHUNK-1)*CHUNK + k];
        s_tvalid = 1;
        for (int n = 0; n < 3; n++) begin
            #0;
            checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_s_tready: got %0b while stalled, required 0", s_tready); end
            checks++; if ({m_tvalid, m_tdata} !== {1'b1, exp_a}) begin errors++; $display("FAIL bp_hold: got v=%0b d=%0d, required v=1 d=%0d", m_tvalid, m_tdata, exp_a); end
            tick();
        end
        m_tready = 1;
        tick();
        s_tvalid = 0;
        checks++; if ({m_tvalid, m_tdata} !== {1'b1, exp_b}) begin errors++; $display("FAIL bp_reload: got v=%0b d=%0d, required v=1 d=%0d", m_tvalid, m_tdata, exp_b); end
        repeat (2) tick();
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL bp_count: got %0d outputs, required 2", obs_q.size()); end
        else begin
            checks++; if ({obs_q[0].d, obs_q[1].d} !== {exp_a, exp_b}) begin errors++; $display("FAIL bp_order: got %0d,%0d, required %0d,%0d", obs_q[0].d, obs_q[1].d, exp_a, exp_b); end
        end
        obs_q.delete();
    endtask

    task automatic test_framing();
        logic [DW-1:0] exp_d;
        obs_q.delete();
        // Partial pixel holding a zero cost that must be discarded.
        fill(0);
        for (int c = 0; c < 3; c++) send_beat(c, c == 0, 1'b0);
        fill_rand(200);
        for (int d = 0; d < MAX_DISP; d++) if (pix[d] == 0) pix[d] = 1;
        exp_d = DW'(ref_argmin());
        send_beat(0, 1'b1, 1'b0);
        checks++; if ({sync_err, busy} !== 2'b11) begin errors++; $display("FAIL restart_pulse: got err=%0b busy=%0b, required 1 1", sync_err, busy); end
        send_beat(1, 1'b0, 1'b0);
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL restart_pulse_width: got %0b, required 0", sync_err); end
        for (int c = 2; c < NCHUNK; c++) send_beat(c, 1'b0, 1'b0);
        tick();
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL restart_count: got %0d outputs, required 1", obs_q.size()); end
        else begin
            checks++; if ({obs_q[0].d, obs_q[0].u} !== {exp_d, 1'b1}) begin errors++; $display("FAIL restart_out: got d=%0d u=%0b, required d=%0d u=1", obs_q[0].d, obs_q[0].u, exp_d); end
        end
        obs_q.delete();
        // Early tlast on chunk 2.
        fill_rand(255);
        exp_d = DW'(ref_argmin());
        for (int c = 0; c < 3; c++) send_beat(c, 1'b0, c == 2);
        checks++; if ({sync_err, m_tvalid} !== 2'b10) begin errors++; $display("FAIL early_tlast: got err=%0b v=%0b, required err=1 v=0", sync_err, m_tvalid); end
        for (int c = 3; c < NCHUNK; c++) send_beat(c, 1'b0, 1'b0);
        tick();
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL tlast_count: got %0d outputs, required 1", obs_q.size()); end
        else begin
            checks++; if ({obs_q[0].d, obs_q[0].l} !== {exp_d, 1'b0}) begin errors++; $display("FAIL tlast_out: got d=%0d l=%0b, required d=%0d l=0", obs_q[0].d, obs_q[0].l, exp_d); end
        end
        obs_q.delete();
    endtask

    task automatic test_random();
        obs_q.delete();
        exp_q.delete();
        rand_bp = 1;
        for (int p = 0; p < 40; p++) begin
            logic u, l;
            u = 1'($urandom_range(0, 1));
            l = 1'($urandom_range(0, 1));
            fill_rand(15);
            exp_q.push_back('{d: DW'(ref_argmin()), u: u, l: l, cyc: 0});
            send_pixel(u, l);
            m_tready = 1'($urandom_range(0, 1));
        end
        rand_bp = 0;
        m_tready = 1;
        repeat (4) tick();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if ({obs_q[i].d, obs_q[i].u, obs_q[i].l} !== {exp_q[i].d, exp_q[i].u, exp_q[i].l}) begin
                errors++; $display("FAIL rand_out%0d: got d=%0d u=%0b l=%0b, required d=%0d u=%0b l=%0b", i,
                    obs_q[i].d, obs_q[i].u, obs_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        m_tready = 0;
        fill_rand(255);
        send_pixel(1'b1, 1'b1);
        for (int c = 0; c < 5; c++) send_beat(c, 1'b0, 1'b0);
        aresetn = 0;
        #1;
        checks++; if ({m_tvalid, m_tdata, m_tuser, m_tlast} !== '0) begin errors++; $display("FAIL midreset_out: got v=%0b d=%0d u=%0b l=%0b, required all 0", m_tvalid, m_tdata, m_tuser, m_tlast); end
        checks++; if ({busy, sync_err, s_tready} !== 3'b001) begin errors++; $display("FAIL midreset_flags: got busy=%0b err=%0b rdy=%0b, required 0 0 1", busy, sync_err, s_tready); end
        tick();
        aresetn  = 1;
        m_tready = 1;
        obs_q.delete();
        fill(255);
        pix[63] = 1;
        send_pixel(1'b0, 1'b0);
        tick();
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL midreset_count: got %0d outputs, required 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].d !== DW'(63)) begin errors++; $display("FAIL midreset_d63: got %0d, required 63", obs_q[0].d); end
        end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_min();
        test_ties();
        test_back_to_back();
        test_backpressure();
        test_framing();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
